system_mem_bridge: RTL and testbench

SYSTEM_MEM_BRIDGE -- requirements
Module: system_mem_bridge

---
 rtl/system_mem_bridge_if.sv | 33 +++
 rtl/system_mem_bridge.sv | 107 ++++++++++
 tb/tb_system_mem_bridge.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/system_mem_bridge_if.sv
// Chip-side request/response and single-port memory bus for system_mem_bridge.
// The bridge connects through the slave modport; the chip/memory side uses master.
interface system_mem_bridge_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 20
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  wr_gnt;
  logic                  flush;
  logic                  busy;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_din;
  logic [WIDTH-1:0]      mem_qout;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, flush, mem_qout,
    output rd_gnt, rd_data, rd_valid, wr_gnt, busy, mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, flush, mem_qout,
    input  rd_gnt, rd_data, rd_valid, wr_gnt, busy, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/system_mem_bridge.sv
// Read/posted-write bridge onto a single-port memory with read-after-write hazard draining.
// Bandwidth counters are built only when SYSTEM_MEM_BRIDGE_BW_CNT_EN is defined.
module system_mem_bridge #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned WR_FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 arst_in,
  system_mem_bridge_if.slave   bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] bw_rd_cnt,
  output logic [CNT_WIDTH-1:0] bw_wr_cnt
);
  localparam int unsigned PtrW = $clog2(WR_FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem [WR_FIFO_DEPTH];
  logic [WIDTH-1:0]      data_mem [WR_FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic                  rd_valid_q;
  logic [WIDTH-1:0]      rd_data_q;

  logic            full, empty, hazard, drain_force, push, pop, rd_issue;
  logic [PtrW-1:0] off;

  always_comb begin
    full   = (count_q == (PtrW+1)'(WR_FIFO_DEPTH));
    empty  = (count_q == '0);
    hazard = 1'b0;
    off    = '0;
    // An entry is live when its distance from the head is below the occupancy.
    for (int i = 0; i < int'(WR_FIFO_DEPTH); i++) begin
      off = PtrW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (addr_mem[i] == bus.rd_addr)) hazard = 1'b1;
    end
    hazard      = hazard & bus.rd_req;
    drain_force = full | bus.flush | hazard;
    push        = bus.wr_req & ~full;
    pop         = ~empty & (drain_force | ~bus.rd_req);
    // No memory read is launched while reset is held.
    rd_issue    = bus.rd_req & ~drain_force & ~arst_in;
  end

  assign bus.wr_gnt   = push;
  assign bus.rd_gnt   = bus.rd_req & ~drain_force;
  assign bus.mem_en   = rd_issue | pop;
  assign bus.mem_we   = pop;
  assign bus.mem_addr = pop ? addr_mem[rd_ptr_q] : (rd_issue ? bus.rd_addr : '0);
  assign bus.mem_din  = pop ? data_mem[rd_ptr_q] : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? bus.mem_qout : rd_data_q;
  assign bus.busy     = ~empty | rd_valid_q;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.wr_addr;
      data_mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      rd_valid_q <= rd_issue;
      if (rd_valid_q) rd_data_q <= bus.mem_qout;
    end
  end

`ifdef SYSTEM_MEM_BRIDGE_BW_CNT_EN
  logic [CNT_WIDTH-1:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (cnt_clr) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_issue && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (pop && !(&wr_cnt_q))      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign bw_rd_cnt = rd_cnt_q;
  assign bw_wr_cnt = wr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign bw_rd_cnt      = '0;
  assign bw_wr_cnt      = '0;
`endif
endmodule

// File: tb/tb_system_mem_bridge.sv
// Directed bench for system_mem_bridge with a 1-cycle-latency memory model.
module tb_system_mem_bridge;
  localparam int AW = 20;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          arst_in;
  logic          cnt_clr;
  logic [CW-1:0] bw_rd_cnt, bw_wr_cnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  system_mem_bridge_if #(.WIDTH(32), .ADDR_WIDTH(AW)) bus ();

  system_mem_bridge #(.WIDTH(32), .ADDR_WIDTH(AW), .WR_FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .arst_in   (arst_in),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .bw_rd_cnt (bw_rd_cnt),
    .bw_wr_cnt (bw_wr_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: never-written words read back as C0D00000 | addr.
  logic [31:0]   mem_arr [256];
  logic [255:0]  wmask = '0;
  logic [31:0]   qout  = '0;
  logic [AW-1:0] wlog [32];
  int            wcnt  = 0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem_arr[bus.mem_addr[7:0]] <= bus.mem_din;
        wmask[bus.mem_addr[7:0]]   <= 1'b1;
        wlog[wcnt % 32]            <= bus.mem_addr;
        wcnt                       <= wcnt + 1;
      end else begin
        qout <= wmask[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]]
                                         : (32'hC0D00000 | 32'(bus.mem_addr));
      end
    end
  end
  assign bus.mem_qout = qout;

  task automatic idle_inputs();
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.flush = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    arst_in = 1'b1;
    @(negedge clk);
    arst_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    arst_in = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 20'h99; bus.wr_req = 1'b1;
    #1;
    n_tests++;
    if ({bus.rd_valid, bus.mem_en, bus.mem_we, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid/en/we/busy=%b want 0000",
               {bus.rd_valid, bus.mem_en, bus.mem_we, bus.busy});
    end
    n_tests++;
    if ({bus.rd_data, bus.mem_addr, bus.mem_din} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got rd_data=%h mem_addr=%h mem_din=%h want 0",
               bus.rd_data, bus.mem_addr, bus.mem_din);
    end
    n_tests++;
    if ({bw_rd_cnt, bw_wr_cnt, bus.wr_gnt} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_cnt_gnt: got rd=%0d wr=%0d wr_gnt=%b want 0 0 1",
               bw_rd_cnt, bw_wr_cnt, bus.wr_gnt);
    end
    @(negedge clk);
    idle_inputs();
    arst_in = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = 20'h10; bus.wr_data = 32'hAAAA;
    #1;
    n_tests++;
    if ({bus.wr_gnt, bus.mem_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL sw_accept: got wr_gnt/mem_en=%b want 10", {bus.wr_gnt, bus.mem_en});
    end
    @(negedge clk);
    bus.wr_req = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !== {2'b11, 20'h10, 32'hAAAA}) begin
      n_fail++;
      $display("FAIL sw_issue: got en=%b we=%b addr=%h din=%h want 1 1 10 0000aaaa",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.mem_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL sw_idle: got busy/mem_en=%b want 00", {bus.busy, bus.mem_en});
    end
    n_tests++;
`ifdef SYSTEM_MEM_BRIDGE_BW_CNT_EN
    if ({bw_wr_cnt, bw_rd_cnt} !== {4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL sw_cnt: got wr=%0d rd=%0d want 1 0", bw_wr_cnt, bw_rd_cnt);
    end
`else
    if ({bw_wr_cnt, bw_rd_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL sw_cnt: got wr=%0d rd=%0d want 0 0", bw_wr_cnt, bw_rd_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int base;
    bit done;
    do_reset();
    base = wcnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b1; bus.rd_addr = 20'h99;
      bus.wr_req = 1'b1; bus.wr_addr = 20'(32'h40 + i); bus.wr_data = 32'hB000 + i;
      #1;
      n_tests++;
      if ({bus.wr_gnt, bus.rd_gnt, bus.mem_we} !== 3'b110) begin
        n_fail++;
        $display("FAIL b2b_fill%0d: got wr_gnt/rd_gnt/we=%b want 110", i,
                 {bus.wr_gnt, bus.rd_gnt, bus.mem_we});
      end
      if (i > 0) begin
        n_tests++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'hC0D00099}) begin
          n_fail++;
          $display("FAIL b2b_rdata%0d: got valid=%b data=%h want 1 c0d00099", i,
                   bus.rd_valid, bus.rd_data);
        end
      end
    end
    @(negedge clk);
    bus.wr_addr = 20'h44; bus.wr_data = 32'hB004;
    #1;
    n_tests++;
    if ({bus.wr_gnt, bus.rd_gnt, bus.mem_we, bus.mem_addr} !== {3'b001, 20'h40}) begin
      n_fail++;
      $display("FAIL b2b_full: got wr_gnt=%b rd_gnt=%b we=%b addr=%h want 0 0 1 40",
               bus.wr_gnt, bus.rd_gnt, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.wr_gnt, bus.rd_gnt} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_after_drain: got wr_gnt/rd_gnt=%b want 11", {bus.wr_gnt, bus.rd_gnt});
    end
    @(negedge clk);
    idle_inputs();
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      #1;
      if (!bus.busy) done = 1'b1;
    end
    n_tests++;
    if (!done || (wcnt - base) != 5) begin
      n_fail++;
      $display("FAIL b2b_drain: got done=%b writes=%0d want 1 5", done, wcnt - base);
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (wlog[(base + k) % 32] !== 20'(32'h40 + k)) begin
        n_fail++;
        $display("FAIL b2b_order%0d: got %h want %h", k, wlog[(base + k) % 32], 32'h40 + k);
      end
    end
  endtask

  task automatic test_hazard();
    do_reset();
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = 20'h20; bus.wr_data = 32'h1234;
    #1;
    n_tests++;
    if (bus.wr_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_accept: got wr_gnt=%b want 1", bus.wr_gnt);
    end
    @(negedge clk);
    bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 20'h20;
    #1;
    n_tests++;
    if ({bus.rd_gnt, bus.mem_we, bus.mem_addr} !== {2'b01, 20'h20}) begin
      n_fail++;
      $display("FAIL hz_block: got rd_gnt=%b we=%b addr=%h want 0 1 20",
               bus.rd_gnt, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.rd_gnt, bus.mem_en, bus.mem_we} !== 3'b110) begin
      n_fail++;
      $display("FAIL hz_grant: got rd_gnt/en/we=%b want 110",
               {bus.rd_gnt, bus.mem_en, bus.mem_we});
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    n_tests++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 32'h1234}) begin
      n_fail++;
      $display("FAIL hz_data: got valid=%b data=%h want 1 00001234", bus.rd_valid, bus.rd_data);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b0, 32'h1234}) begin
      n_fail++;
      $display("FAIL hz_hold: got valid=%b data=%h want 0 00001234", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b1; bus.rd_addr = 20'h99;
      bus.wr_req = 1'b1; bus.wr_addr = 20'(32'h30 + i); bus.wr_data = 32'hF00 + i;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_req = 1'b0; bus.flush = 1'b1;
      #1;
      n_tests++;
      if ({bus.rd_gnt, bus.mem_we, bus.busy, bus.mem_addr} !== {3'b011, 20'(32'h30 + i)}) begin
        n_fail++;
        $display("FAIL flush_drain%0d: got rd_gnt=%b we=%b busy=%b addr=%h want 0 1 1 %h", i,
                 bus.rd_gnt, bus.mem_we, bus.busy, bus.mem_addr, 32'h30 + i);
      end
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.rd_gnt, bus.mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_done: got busy/rd_gnt/en=%b want 000",
               {bus.busy, bus.rd_gnt, bus.mem_en});
    end
  endtask

  task automatic test_reset_mid();
    int  base;
    bit  seen;
    do_reset();
    base = wcnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b1; bus.rd_addr = 20'h99;
      bus.wr_req = 1'b1; bus.wr_addr = 20'(32'h50 + i); bus.wr_data = 32'hD00 + i;
    end
    @(negedge clk);
    bus.wr_req = 1'b0;
    #1;
    n_tests++;
    if (bus.rd_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_inflight: got rd_gnt=%b want 1", bus.rd_gnt);
    end
    #2;
    arst_in = 1'b1;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.rd_valid, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rm_async: got en/valid/busy=%b want 000",
               {bus.mem_en, bus.rd_valid, bus.busy});
    end
    @(negedge clk);
    arst_in = 1'b0;
    idle_inputs();
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.rd_valid || bus.mem_en) seen = 1'b1;
    end
    n_tests++;
    if ({seen, bus.busy} !== 2'b00 || wcnt != base) begin
      n_fail++;
      $display("FAIL rm_after: got activity=%b busy=%b writes=%0d want 0 0 0",
               seen, bus.busy, wcnt - base);
    end
    n_tests++;
    if ({bw_rd_cnt, bw_wr_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL rm_cnt: got rd=%0d wr=%0d want 0 0", bw_rd_cnt, bw_wr_cnt);
    end
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b1; bus.rd_addr = 20'h99;
    end
    @(negedge clk);
    #1;
    n_tests++;
`ifdef SYSTEM_MEM_BRIDGE_BW_CNT_EN
    if (bw_rd_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL cnt_sat: got %0d want 15", bw_rd_cnt);
    end
`else
    if (bw_rd_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL cnt_off: got %0d want 0", bw_rd_cnt);
    end
`endif
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; bus.rd_req = 1'b0;
    #1;
    n_tests++;
    if ({bw_rd_cnt, bw_wr_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL cnt_clr: got rd=%0d wr=%0d want 0 0", bw_rd_cnt, bw_wr_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_reset_mid();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
